// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor D = A - B, LSB first, one bit per clock.
// Optional SERIAL_SUB_SAT_EN clamps D to 0 on borrow.
module serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic a0, nb0, prop, dbit, cout, last;

  // Full-subtract cell: A + ~B + carry, carry seeded with 1.
  assign a0   = a_q[0];
  assign nb0  = ~b_q[0];
  assign prop = a0 ^ nb0;
  assign dbit = prop ^ carry;
  assign cout = (a0 & nb0) | (carry & prop);
  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      D      <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      carry  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q    <= A;
            b_q    <= B;
            D      <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            carry  <= 1'b1;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          cnt   <= cnt + 1'b1;
          carry <= cout;
          D     <= {dbit, D[WIDTH-1:1]};
          if (last) begin
            borrow <= ~cout;
`ifdef SERIAL_SUB_SAT_EN
            if (!cout) D <= '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub (WIDTH=4).
// Expected values follow SERIAL_SUB_SAT_EN when it is defined.
module tb_serial_sub;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A, B;
  logic         busy, done, borrow;
  logic [W-1:0] D;

  int n_cmp = 0;
  int n_err = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .borrow(borrow)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n === 1'b1)
      assert (!$isunknown(start))
      else $error("FAIL start_known: start=%b", start);

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_d(input logic [W-1:0] wrap,
                                         input logic b);
`ifdef SERIAL_SUB_SAT_EN
    return b ? '0 : wrap;
`else
    return wrap;
`endif
  endfunction

  task automatic do_op(input string tag, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] wd,
                       input logic eb);
    int k;
    int nb;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0; nb = 0;
    while (done !== 1'b1 && k < 20) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, k, W);
    check({tag, "_busy"}, nb, W);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_D"}, D, exp_d(wd, eb));
    check({tag, "_borrow"}, borrow, eb);
    @(negedge clk);
    check({tag, "_pulse"}, done, 1'b0);
    check({tag, "_hold"}, {borrow, D}, {eb, exp_d(wd, eb)});
  endtask

  initial begin
    int ndone;
    int t0, t1, cyc;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    check("rst_state", {busy, done, borrow, D}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle", {busy, done}, 2'b00);

    do_op("9m3",  4'd9,  4'd3,  4'd6,  1'b0);
    do_op("3m9",  4'd3,  4'd9,  4'hA,  1'b1);
    do_op("0m0",  4'd0,  4'd0,  4'd0,  1'b0);
    do_op("Fm F", 4'd15, 4'd15, 4'd0,  1'b0);
    do_op("0m1",  4'd0,  4'd1,  4'd15, 1'b1);
    do_op("Fm0",  4'd15, 4'd0,  4'd15, 1'b0);

    // start pulsed mid-RUN with new operands must be ignored
    @(negedge clk);
    A = 4'd9; B = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 4'd1; B = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) begin
        ndone++;
        check("ign_D", D, 4'd6);
      end
      @(negedge clk);
    end
    check("ign_ndone", ndone, 1);
    check("ign_busy", busy, 1'b0);

    // reset during RUN
    A = 4'd3; B = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstrun_out", {busy, done, borrow, D}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    check("rstrun_nodone", ndone, 0);
    do_op("7m2", 4'd7, 4'd2, 4'd5, 1'b0);

    // start held: back-to-back operations
    A = 4'd5; B = 4'd1; start = 1'b1;
    t0 = -1; t1 = -1; cyc = 0;
    while (t1 < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        check("b2b_D", D, 4'd4);
        if (t0 < 0) t0 = cyc;
        else t1 = cyc;
      end
    end
    start = 1'b0;
    check("b2b_gap", t1 - t0, W + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
